// File: rtl/button_event_if.sv
// Button event interface: debounced level and tick strobe in, event strobes
// and held level out. The master side drives btn_i/tick_i; the slave side
// (button_event) drives the registered outputs.
interface button_event_if;
  logic tick_i;
  logic btn_i;
  logic press_o;
  logic release_o;
  logic long_press_o;
  logic repeat_o;
  logic held_o;

  modport master (
    output tick_i,
    output btn_i,
    input  press_o,
    input  release_o,
    input  long_press_o,
    input  repeat_o,
    input  held_o
  );

  modport slave (
    input  tick_i,
    input  btn_i,
    output press_o,
    output release_o,
    output long_press_o,
    output repeat_o,
    output held_o
  );
endinterface

// File: rtl/button_event.sv
// button_event: turns a debounced button level into single-cycle press,
// release, long-press and (optionally) auto-repeat strobes plus a held level.
// Hold timing is counted in tick strobes, not clk cycles.
// Optional feature macro: BUTTON_EVENT_AUTO_REPEAT_EN enables repeat pulses
// every REPEAT_TICKS while in the long-hold state; without it repeat_o is 0.
module button_event #(
  parameter int CNT_W        = 10,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input logic           clk,
  input logic           rst_n,
  button_event_if.slave ev_if
);

  // Reject parameter sets the counter cannot represent.
  if ((LONG_TICKS < 1) || (REPEAT_TICKS < 1) ||
      ((2 ** CNT_W) <= LONG_TICKS) || ((2 ** CNT_W) <= REPEAT_TICKS)) begin : g_param_check
    $error("button_event: LONG_TICKS/REPEAT_TICKS out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  logic rise;
  logic fall;

  assign rise = ev_if.btn_i & ~btn_q;
  assign fall = ~ev_if.btn_i & btn_q;

  // Next state, tick counter and event strobes; fall takes priority over any tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = PRESSED;
        end
      end

      PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (ev_if.tick_i) begin
          if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            cnt_d   = '0;
            state_d = LONG;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      LONG: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (ev_if.tick_i) begin
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
          if (cnt_q == REP_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          cnt_d = '0;
`endif
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    held_d = (state_d != IDLE);
  end

  // State, counter, edge-detect history and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= ev_if.btn_i;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign ev_if.press_o      = press_q;
  assign ev_if.release_o    = release_q;
  assign ev_if.long_press_o = long_q;
  assign ev_if.repeat_o     = repeat_q;
  assign ev_if.held_o       = held_q;

endmodule
